lfsr_result_collector: RTL

- Downstream consumer of the serial output of the LFSR chain.
- Discards a configurable number of start-up bits, then deserialises the bit stream into words; the first received bit is the word MSB.
- Presents each word on a valid/ready output port with a single holding register.
- Maintains a running 32-bit MISR signature and a count of loaded words, so a bench compares one value instead of a long result dump.

---
 rtl/lfsr_result_collector.sv | 89 ++++++++
 1 files changed

// File: rtl/lfsr_result_collector.sv
// Serial-to-word collector for the LFSR chain output. It discards SKIP start-up bits,
// deserialises MSB-first words into a one-deep valid/ready holding register, and keeps a 32-bit MISR.
module lfsr_result_collector #(
    parameter int WORD_W = 32,
    parameter int SKIP   = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_in,
    input  logic              bit_en,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              overflow,
    output logic [CNT_W-1:0]  word_count,
    output logic [31:0]       signature,
    output logic              collecting
);

    localparam int                BIT_CW    = $clog2(WORD_W);
    localparam logic [BIT_CW-1:0] BIT_LAST  = BIT_CW'(WORD_W - 1);
    localparam logic [15:0]       SKIP_LAST = (SKIP > 0) ? 16'(SKIP - 1) : 16'd0;
    localparam logic [31:0]       POLY      = 32'h04C11DB7;

    typedef enum logic {ST_SKIP, ST_COLLECT} state_t;
    localparam state_t ST_INIT = (SKIP == 0) ? ST_COLLECT : ST_SKIP;

    state_t            state, state_next;
    logic [15:0]       skip_cnt;
    logic [BIT_CW-1:0] bit_cnt;
    logic [WORD_W-1:0] shift, shift_next;
    logic              complete, load;

    function automatic logic [31:0] sig_step(input logic [31:0] sig, input logic [WORD_W-1:0] w);
        return ({sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'h0)) ^ 32'(w);
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_INIT;
        else        state <= state_next;
    end

    // NOTE: the default assignment first keeps this combinational block from inferring a latch.
    always_comb begin
        state_next = state;
        if (state == ST_SKIP && bit_en && skip_cnt == SKIP_LAST)
            state_next = ST_COLLECT;
    end

    assign collecting = (state == ST_COLLECT);
    assign shift_next = {shift[WORD_W-2:0], bit_in};
    assign complete   = collecting && bit_en && (bit_cnt == BIT_LAST);
    // A completed word loads if the holder is empty or being drained on this same edge.
    assign load       = complete && (!word_valid || word_ready);

    always_ff @(posedge clk) begin
        if (!reset) begin
            skip_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            overflow   <= 1'b0;
            word_count <= '0;
            signature  <= '0;
        end else begin
            if (state == ST_SKIP && bit_en)
                skip_cnt <= skip_cnt + 16'd1;
            if (collecting && bit_en) begin
                shift   <= shift_next;
                bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
            end
            if (load) begin
                word_data  <= shift_next;
                word_valid <= 1'b1;
                if (word_count != '1)
                    word_count <= word_count + 1'b1;
                signature  <= sig_step(signature, shift_next);
            end else if (complete) begin
                overflow <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule
